// File: rtl/cape_io_pkg.sv
// Shared definitions for the cape I/O pin drivers: dwell FSM state encoding
// and state-decode helpers.
package cape_io_pkg;

  typedef enum logic [1:0] {
    LOW_IDLE  = 2'd0,
    LOW_HOLD  = 2'd1,
    HIGH_HOLD = 2'd2,
    HIGH_IDLE = 2'd3
  } dwell_state_e;

  function automatic logic state_is_high(dwell_state_e s);
    return (s == HIGH_HOLD) || (s == HIGH_IDLE);
  endfunction

  function automatic logic state_is_hold(dwell_state_e s);
    return (s == HIGH_HOLD) || (s == LOW_HOLD);
  endfunction

endpackage

// File: rtl/dwell_driver_if.sv
// Request/status bundle of the dwell driver, with a debug view of its FSM.
interface dwell_driver_if #(
  parameter int PEND_W = 3
);

  // No valid/ready pairs: mode and level_in are levels, pulse_in and ovf_clr are
  // single-cycle strobes, all sampled on every rising clock edge and never back-pressured.
  logic                     mode;
  logic                     level_in;
  logic                     pulse_in;
  logic                     ovf_clr;
  logic                     drive_out;
  logic                     busy;
  logic [PEND_W-1:0]        pend_count;
  logic                     overflow;
  cape_io_pkg::dwell_state_e dbg_state;

  modport master (
    output mode, level_in, pulse_in, ovf_clr,
    input  drive_out, busy, pend_count, overflow, dbg_state
  );

  modport slave (
    input  mode, level_in, pulse_in, ovf_clr,
    output drive_out, busy, pend_count, overflow, dbg_state
  );

endinterface

// File: rtl/dwell_driver.sv
// Chatter-free pin driver: enforces minimum high/low dwell times, in level mode
// (follow level_in) or pulse mode (issue queued fixed-width pulses).
module dwell_driver
  import cape_io_pkg::*;
#(
  parameter int MIN_HIGH_CYCLES = 8191,
  parameter int MIN_LOW_CYCLES  = 8191,
  parameter int PEND_W          = 3
) (
  input  logic           clk,
  input  logic           resetn,
  dwell_driver_if.slave  bus
);

  localparam int MAX_DWELL = (MIN_HIGH_CYCLES > MIN_LOW_CYCLES) ? MIN_HIGH_CYCLES : MIN_LOW_CYCLES;
  localparam int CNT_W     = $clog2(MAX_DWELL + 1);
  localparam logic [CNT_W-1:0]  HIGH_LOAD = CNT_W'(MIN_HIGH_CYCLES - 1);
  localparam logic [CNT_W-1:0]  LOW_LOAD  = CNT_W'(MIN_LOW_CYCLES - 1);
  localparam logic [PEND_W-1:0] PEND_MAX  = '1;

  dwell_state_e      state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic              ovf_q, ovf_d;
  logic              drive_q, busy_q;
  logic              consume;
  logic              hold_running;

  // A hold with a nonzero counter is untouchable; mode and level_in only matter
  // in an IDLE state or on the last hold cycle (counter == 0).
  assign hold_running = state_is_hold(state_q) && (cnt_q != '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    consume = 1'b0;
    if (hold_running) begin
      cnt_d = cnt_q - 1'b1;
    end else begin
      unique case (state_q)
        LOW_IDLE, LOW_HOLD: begin
          if (bus.mode ? (pend_q != '0) : bus.level_in) begin
            state_d = HIGH_HOLD;
            cnt_d   = HIGH_LOAD;
            consume = bus.mode;
          end else begin
            state_d = LOW_IDLE;
          end
        end
        HIGH_HOLD, HIGH_IDLE: begin
          if (bus.mode || !bus.level_in) begin
            state_d = LOW_HOLD;
            cnt_d   = LOW_LOAD;
          end else begin
            state_d = HIGH_IDLE;
          end
        end
        default: state_d = LOW_IDLE;
      endcase
    end
  end

  // Pending queue: a simultaneous request and consume cancel out, so only a
  // lone request at saturation is dropped and flagged.
  always_comb begin
    pend_d = pend_q;
    ovf_d  = ovf_q;
    if (bus.ovf_clr) ovf_d = 1'b0;
    if (bus.pulse_in && !consume) begin
      if (pend_q == PEND_MAX) ovf_d  = 1'b1;
      else                    pend_d = pend_q + 1'b1;
    end else if (consume && !bus.pulse_in) begin
      pend_d = pend_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= LOW_IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
      drive_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      drive_q <= state_is_high(state_d);
      busy_q  <= state_is_hold(state_d);
    end
  end

  assign bus.drive_out  = drive_q;
  assign bus.busy       = busy_q;
  assign bus.pend_count = pend_q;
  assign bus.overflow   = ovf_q;
  assign bus.dbg_state  = state_q;

endmodule

// File: tb/tb_dwell_driver.sv
// Directed bench for dwell_driver with MIN_HIGH=4, MIN_LOW=3, PEND_W=2.
module tb_dwell_driver;
  import cape_io_pkg::*;

  logic clk;
  logic resetn;
  int   n_cmp;
  int   n_bad;

  // Expected per-cycle {pend_count[1:0], busy, drive_out}
  logic [3:0] exp_q[$];

  dwell_driver_if #(.PEND_W(2)) bus ();

  dwell_driver #(
    .MIN_HIGH_CYCLES(4),
    .MIN_LOW_CYCLES (3),
    .PEND_W         (2)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_n(input logic [3:0] v, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(v);
  endtask

  // Scoreboard: pulse_in is held high for the first n_pulse edges
  task automatic run_exp(input string tag, input int n_pulse);
    int i;
    logic [3:0] e;
    i = 0;
    while (exp_q.size() > 0) begin
      bus.pulse_in = (i < n_pulse);
      step();
      e = exp_q.pop_front();
      check(tag, {bus.pend_count, bus.busy, bus.drive_out}, e);
      i++;
    end
    bus.pulse_in = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    resetn       = 1'b0;
    bus.mode     = 1'b0;
    bus.level_in = 1'b0;
    bus.pulse_in = 1'b0;
    bus.ovf_clr  = 1'b0;
    #23;
    check("rst_drive", bus.drive_out, 0);
    check("rst_busy",  bus.busy, 0);
    check("rst_pend",  bus.pend_count, 0);
    check("rst_ovf",   bus.overflow, 0);
    check("rst_state", bus.dbg_state, LOW_IDLE);
    @(negedge clk);
    resetn = 1'b1;
    step();

    // Level held high 20 cycles: 4 busy-high cycles, then HIGH_IDLE
    bus.level_in = 1'b1;
    push_n(4'b0011, 4);
    push_n(4'b0001, 16);
    run_exp("lvl_hold", 0);
    check("lvl_high_idle", bus.dbg_state, HIGH_IDLE);
    bus.level_in = 1'b0;
    push_n(4'b0010, 3);
    push_n(4'b0000, 2);
    run_exp("lvl_fall", 0);
    check("lvl_low_idle", bus.dbg_state, LOW_IDLE);

    // One-cycle level request: exactly 4 high, then at least 3 low
    bus.level_in = 1'b1;
    step();
    check("short_rise", {bus.busy, bus.drive_out}, 2'b11);
    bus.level_in = 1'b0;
    push_n(4'b0011, 3);
    push_n(4'b0010, 3);
    push_n(4'b0000, 2);
    run_exp("short_lvl", 0);

    // Pulse mode, three back-to-back requests
    bus.mode = 1'b1;
    push_n(4'b0100, 1);
    push_n(4'b0111, 1);
    push_n(4'b1011, 3);
    push_n(4'b1010, 3);
    push_n(4'b0111, 4);
    push_n(4'b0110, 3);
    push_n(4'b0011, 4);
    push_n(4'b0010, 3);
    push_n(4'b0000, 1);
    run_exp("pulse3", 3);
    check("pulse3_ovf", bus.overflow, 0);

    // Saturation and overflow while the first pulse is high
    bus.pulse_in = 1'b1;
    step();
    check("sat_pend1", bus.pend_count, 1);
    bus.pulse_in = 1'b0;
    step();
    check("sat_first_high", {bus.pend_count, bus.drive_out}, 3'b001);
    bus.pulse_in = 1'b1;
    repeat (5) step();
    check("sat_pend", bus.pend_count, 3);
    check("sat_ovf", bus.overflow, 1);
    bus.ovf_clr = 1'b1;
    step();
    check("ovf_set_wins", bus.overflow, 1);
    check("sat_pend_hold", bus.pend_count, 3);
    bus.pulse_in = 1'b0;
    step();
    check("ovf_cleared", bus.overflow, 0);
    check("sat_consume", {bus.pend_count, bus.drive_out}, 3'b101);
    bus.ovf_clr = 1'b0;
    repeat (30) step();
    check("drain_pend", bus.pend_count, 0);
    check("drain_state", bus.dbg_state, LOW_IDLE);

    // Mode switch to pulse mid high-hold: hold still completes 4 cycles
    bus.mode = 1'b0;
    bus.level_in = 1'b1;
    step();
    check("msw_rise", bus.dbg_state, HIGH_HOLD);
    bus.mode = 1'b1;
    repeat (3) step();
    check("msw_still_high", {bus.busy, bus.drive_out}, 2'b11);
    step();
    check("msw_fall", {bus.busy, bus.drive_out}, 2'b10);
    check("msw_low_hold", bus.dbg_state, LOW_HOLD);
    bus.level_in = 1'b0;
    repeat (3) step();
    check("msw_idle", bus.dbg_state, LOW_IDLE);

    // Level mode retains queued pulses, then reset mid high-hold
    bus.mode = 1'b0;
    bus.pulse_in = 1'b1;
    step();
    bus.pulse_in = 1'b0;
    repeat (2) step();
    check("lvl_retain_pend", bus.pend_count, 1);
    bus.level_in = 1'b1;
    repeat (2) step();
    check("pre_rst_state", bus.dbg_state, HIGH_HOLD);
    #3;
    resetn = 1'b0;
    #1;
    check("async_drive", bus.drive_out, 0);
    check("async_busy", bus.busy, 0);
    check("async_pend", bus.pend_count, 0);
    check("async_state", bus.dbg_state, LOW_IDLE);
    @(negedge clk);
    resetn = 1'b1;
    step();
    check("post_rst_rise", {bus.busy, bus.drive_out}, 2'b11);

    // One-cycle low glitch inside the hold is absorbed
    bus.level_in = 1'b0;
    step();
    bus.level_in = 1'b1;
    repeat (3) step();
    check("glitch_absorbed", bus.dbg_state, HIGH_IDLE);
    check("glitch_drive", bus.drive_out, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dwell_driver.md
DWELL_DRIVER -- requirements
Module: dwell_driver

Interface
REQ-001 SHALL have parameter MIN_HIGH_CYCLES, default 8191, minimum cycles drive_out stays high once asserted (legal range >=1).
REQ-002 SHALL have parameter MIN_LOW_CYCLES, default 8191, minimum cycles drive_out stays low once deasserted (legal range >=1).
REQ-003 SHALL have parameter PEND_W, default 3, width of the pending-pulse counter.
REQ-004 SHALL have port clk  input  1  single clock, rising edge.
REQ-005 SHALL have port resetn  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port mode  input  1  0 = level mode, 1 = pulse mode; synchronous to clk.
REQ-007 SHALL have port level_in  input  1  requested output level (level mode); synchronous to clk.
REQ-008 SHALL have port pulse_in  input  1  single-cycle request for one output pulse (pulse mode); synchronous to clk.
REQ-009 SHALL have port ovf_clr  input  1  clears the overflow flag.
REQ-010 SHALL have port drive_out  output  1  registered pin drive, chatter-free.
REQ-011 SHALL have port busy  output  1  high while a minimum-dwell hold is running.
REQ-012 SHALL have port pend_count  output  PEND_W  queued pulse requests not yet issued.
REQ-013 SHALL have port overflow  output  1  sticky, set when a pulse request is dropped.

Function
REQ-014 SHALL implement states LOW_IDLE, LOW_HOLD, HIGH_HOLD, HIGH_IDLE; drive_out = 1 in HIGH_* states, 0 in LOW_* states, all outputs registered.
REQ-015 On entry to HIGH_HOLD the dwell counter SHALL load MIN_HIGH_CYCLES-1; on entry to LOW_HOLD it SHALL load MIN_LOW_CYCLES-1; it SHALL decrement each cycle in a HOLD state while nonzero.
REQ-016 HOLD with counter==0 SHALL be the last hold cycle, so drive_out holds each level for at least exactly MIN_*_CYCLES cycles.
REQ-017 Level mode, LOW_IDLE or last LOW_HOLD cycle: level_in=1 -> HIGH_HOLD at that edge (one-cycle latency); else LOW_HOLD ends in LOW_IDLE.
REQ-018 Level mode, HIGH_IDLE or last HIGH_HOLD cycle: level_in=0 -> LOW_HOLD at that edge; else HIGH_HOLD ends in HIGH_IDLE.
REQ-019 Level mode: level_in changes during a hold SHALL be ignored except as sampled at the last hold cycle; glitches shorter than the hold are absorbed.
REQ-020 Pulse mode, LOW_IDLE or last LOW_HOLD cycle with pend_count>0 SHALL -> HIGH_HOLD and decrement pend_count.
REQ-021 Pulse mode, last HIGH_HOLD cycle or HIGH_IDLE SHALL -> LOW_HOLD unconditionally; each output pulse is exactly MIN_HIGH_CYCLES wide, back-to-back period MIN_HIGH_CYCLES+MIN_LOW_CYCLES.
REQ-022 pulse_in=1 SHALL increment pend_count in either mode; pend_count SHALL saturate at 2**PEND_W-1.
REQ-023 pulse_in arriving at saturation SHALL be dropped and set overflow; simultaneous pulse_in and consume SHALL leave pend_count unchanged and never overflow.
REQ-024 ovf_clr SHALL clear overflow; simultaneous set and ovf_clr SHALL leave overflow set.
REQ-025 mode SHALL be evaluated only at IDLE states or last hold cycle; a mode change never shortens a running hold.
REQ-026 In level mode pend_count SHALL be retained (not consumed, not cleared).
REQ-027 busy SHALL equal 1 exactly in LOW_HOLD and HIGH_HOLD.

Reset
REQ-028 resetn low SHALL asynchronously force LOW_IDLE, drive_out=0, busy=0, dwell counter 0, pend_count 0, overflow 0.
REQ-029 Reset mid-hold or mid-pulse SHALL abort immediately; after release no low hold is owed (a request may raise drive_out on the first edge).

Structure
REQ-030 State encoding constants SHALL live in shared package cape_io_pkg; parameters stay local.
REQ-031 The dwell counter SHALL be sized $clog2 of max(MIN_HIGH_CYCLES, MIN_LOW_CYCLES)+1 bits.
REQ-032 No sub-module; single state machine plus counter, pending counter, overflow flag.

Verification (MIN_HIGH_CYCLES=4, MIN_LOW_CYCLES=3, PEND_W=2)
REQ-033 Level mode, level_in 0->1 held 20 cycles -> drive_out rises one edge later, busy high 4 cycles, then HIGH_IDLE.
REQ-034 Level mode, level_in high for 1 cycle -> drive_out high exactly 4 cycles, then low at least 3 cycles.
REQ-035 Pulse mode, 3 pulse_in on consecutive cycles -> 3 output pulses of 4 cycles high, 3 cycles low between, pend_count 0 at end, overflow 0.
REQ-036 Pulse mode, 5 pulse_in in consecutive cycles while first pulse high -> pend_count saturates at 3, overflow set; ovf_clr clears it.
REQ-037 Reset asserted in HIGH_HOLD cycle 2 -> drive_out 0 asynchronously; pend_count 0; post-release level_in=1 rises drive_out on first edge.
REQ-038 Mode switched 0->1 during HIGH_HOLD with level_in=1 -> hold completes 4 cycles, then LOW_HOLD.
